gpu_net_interface: RTL and testbench

- GPU-side endpoint for the leaf router's GPU port. Host pushes (payload, 6-bit destination) through a TX FIFO; the block paces flits onto the router's valid-only GPU input.
- Captures every flit the router delivers on its GPU output into an RX FIFO for the host to pop.
- The router GPU port has no backpressure, so TX is rate-limited by a programmable inter-flit gap, and RX overflow is counted as drops.

---
 rtl/gpu_ni_pkg.sv | 28 ++
 rtl/gpu_net_interface_fifo.sv | 46 ++++
 rtl/gpu_net_interface.sv | 149 ++++++++++++++
 tb/tb_gpu_net_interface.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_ni_pkg.sv
// Shared definitions for the GPU network interface: address fields,
// TX FSM states and the drop counter width.
package gpu_ni_pkg;

  localparam int ADDR_W     = 6;
  localparam int GROUP_LSB  = 2;
  localparam int GROUP_W    = 4;
  localparam int LEAF_LSB   = 0;
  localparam int LEAF_W     = 2;
  localparam int DROP_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

  // Router group selected by dest[5:2].
  function automatic logic [GROUP_W-1:0] dest_group(input logic [ADDR_W-1:0] dest);
    return dest[GROUP_LSB +: GROUP_W];
  endfunction

  // Port on the leaf router selected by dest[1:0].
  function automatic logic [LEAF_W-1:0] dest_leaf(input logic [ADDR_W-1:0] dest);
    return dest[LEAF_LSB +: LEAF_W];
  endfunction

endpackage

// File: rtl/gpu_net_interface_fifo.sv
// Synchronous FIFO with first-word fall-through output; an extra pointer
// bit separates full from empty.
module ni_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gpu_net_interface.sv
// GPU-side network endpoint: paces host flits onto the router's valid-only
// GPU input and buffers router deliveries for the host.
module gpu_net_interface
  import gpu_ni_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic [DWIDTH-1:0]     host_tx_data,
  input  logic [ADDR_W-1:0]     host_tx_dest,
  input  logic                  host_tx_valid,
  output logic                  host_tx_ready,
  output logic [DWIDTH-1:0]     host_rx_data,
  output logic                  host_rx_valid,
  input  logic                  host_rx_ready,
  output logic [DWIDTH-1:0]     gpu_in_data,
  output logic                  gpu_in_valid,
  output logic [ADDR_W-1:0]     gpu_dest_addr,
  input  logic [DWIDTH-1:0]     gpu_out_data,
  input  logic                  gpu_out_valid,
  output logic                  tx_busy,
  output logic [CNT_WIDTH-1:0]  tx_flit_count,
  output logic [CNT_WIDTH-1:0]  rx_flit_count,
  output logic [DROP_CNT_W-1:0] rx_drop_count
);

  localparam int TXW = DWIDTH + ADDR_W;
  localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic            tx_full, tx_empty, tx_push, tx_pop;
  logic [TXW-1:0]  tx_dout;
  logic            rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic [DWIDTH-1:0] rx_dout;

  tx_state_t         state, state_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic              valid_n, count_flit;
  logic [DWIDTH-1:0] data_n;
  logic [ADDR_W-1:0] dest_n;

  assign host_tx_ready = !tx_full;
  assign tx_push       = host_tx_valid && !tx_full;
  assign tx_busy       = (state != IDLE);

  ni_sync_fifo #(.WIDTH(TXW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   ({host_tx_dest, host_tx_data}),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_comb begin
    state_n    = state;
    gap_n      = gap_cnt;
    valid_n    = gpu_in_valid;
    data_n     = gpu_in_data;
    dest_n     = gpu_dest_addr;
    tx_pop     = 1'b0;
    count_flit = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && !tx_empty) begin
          {dest_n, data_n} = tx_dout;
          tx_pop           = 1'b1;
          valid_n          = 1'b1;
          state_n          = SEND;
        end
      end
      SEND: begin
        count_flit = 1'b1;
        if (GAP_CYCLES == 0 && tx_enable && !tx_empty) begin
          {dest_n, data_n} = tx_dout;
          tx_pop           = 1'b1;
        end else begin
          valid_n = 1'b0;
          gap_n   = '0;
          state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      gap_cnt       <= '0;
      gpu_in_valid  <= 1'b0;
      gpu_in_data   <= '0;
      gpu_dest_addr <= '0;
      tx_flit_count <= '0;
    end else begin
      state         <= state_n;
      gap_cnt       <= gap_n;
      gpu_in_valid  <= valid_n;
      gpu_in_data   <= data_n;
      gpu_dest_addr <= dest_n;
      if (count_flit) tx_flit_count <= tx_flit_count + CNT_WIDTH'(1);
    end
  end

  // The router cannot be stalled, so anything that does not fit is dropped.
  assign rx_pop  = host_rx_ready && !rx_empty;
  assign rx_push = gpu_out_valid && (!rx_full || rx_pop);
  assign rx_drop = gpu_out_valid && !rx_push;

  ni_sync_fifo #(.WIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (gpu_out_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign host_rx_valid = !rx_empty;
  assign host_rx_data  = rx_empty ? '0 : rx_dout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_flit_count <= '0;
      rx_drop_count <= '0;
    end else begin
      if (rx_push) rx_flit_count <= rx_flit_count + CNT_WIDTH'(1);
      if (rx_drop && rx_drop_count != '1) rx_drop_count <= rx_drop_count + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gpu_net_interface.sv
// Self-checking bench for gpu_net_interface: directed scenarios plus random
// traffic, compared against a queue-based behavioural model.
module tb_gpu_net_interface;

  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int TB_GAP = 1;
  localparam int CW     = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_enable = 1'b0;
  logic [DW-1:0] host_tx_data = '0;
  logic [5:0]    host_tx_dest = '0;
  logic          host_tx_valid = 1'b0;
  logic          host_tx_ready;
  logic [DW-1:0] host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready = 1'b0;
  logic [DW-1:0] gpu_in_data;
  logic          gpu_in_valid;
  logic [5:0]    gpu_dest_addr;
  logic [DW-1:0] gpu_out_data = '0;
  logic          gpu_out_valid = 1'b0;
  logic          tx_busy;
  logic [CW-1:0] tx_flit_count;
  logic [CW-1:0] rx_flit_count;
  logic [7:0]    rx_drop_count;

  always #5 clk = ~clk;

  gpu_net_interface #(
    .DWIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(TB_GAP), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_enable     (tx_enable),
    .host_tx_data  (host_tx_data),
    .host_tx_dest  (host_tx_dest),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .gpu_in_data   (gpu_in_data),
    .gpu_in_valid  (gpu_in_valid),
    .gpu_dest_addr (gpu_dest_addr),
    .gpu_out_data  (gpu_out_data),
    .gpu_out_valid (gpu_out_valid),
    .tx_busy       (tx_busy),
    .tx_flit_count (tx_flit_count),
    .rx_flit_count (rx_flit_count),
    .rx_drop_count (rx_drop_count)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: FIFOs as queues, TX pacing as "earliest next launch edge".
  logic [21:0] tx_q[$];
  logic [15:0] rx_q[$];
  int          next_allowed;
  bit          exp_valid;
  bit          launch_prev;
  logic [15:0] exp_data;
  logic [5:0]  exp_dest;
  int          exp_tx_cnt;
  int          exp_rx_cnt;
  int          exp_drop;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic modelReset();
    tx_q.delete();
    rx_q.delete();
    next_allowed = 0;
    exp_valid    = 0;
    launch_prev  = 0;
    exp_data     = '0;
    exp_dest     = '0;
    exp_tx_cnt   = 0;
    exp_rx_cnt   = 0;
    exp_drop     = 0;
    cyc          = 0;
  endtask

  task automatic modelEdge(input int e, input bit en, input bit txv, input logic [21:0] txw,
                           input bit ov, input logic [15:0] od, input bit rxr);
    int  txs;
    bit  rpop;
    bit  rwr;
    txs = tx_q.size();
    if (launch_prev) exp_tx_cnt++;
    launch_prev = 0;
    exp_valid   = 0;
    if (en && txs > 0 && e >= next_allowed) begin
      {exp_dest, exp_data} = tx_q.pop_front();
      exp_valid    = 1;
      launch_prev  = 1;
      next_allowed = e + TB_GAP + 2;
    end
    if (txv && txs < DEPTH) tx_q.push_back(txw);
    rpop = rxr && (rx_q.size() > 0);
    rwr  = ov && (rx_q.size() < DEPTH || rpop);
    if (rpop) void'(rx_q.pop_front());
    if (rwr) begin
      rx_q.push_back(od);
      exp_rx_cnt++;
    end else if (ov && exp_drop < 255) begin
      exp_drop++;
    end
  endtask

  task automatic checkAll();
    checkOutput("in_valid", 32'(gpu_in_valid), 32'(exp_valid));
    checkOutput("in_data", 32'(gpu_in_data), 32'(exp_data));
    checkOutput("in_dest", 32'(gpu_dest_addr), 32'(exp_dest));
    checkOutput("tx_busy", 32'(tx_busy), 32'(cyc < next_allowed - 1));
    checkOutput("tx_cnt", 32'(tx_flit_count), 32'(exp_tx_cnt & 16'hFFFF));
    checkOutput("tx_ready", 32'(host_tx_ready), 32'(tx_q.size() < DEPTH));
    checkOutput("rx_valid", 32'(host_rx_valid), 32'(rx_q.size() > 0));
    if (rx_q.size() > 0) checkOutput("rx_data", 32'(host_rx_data), 32'(rx_q[0]));
    checkOutput("rx_cnt", 32'(rx_flit_count), 32'(exp_rx_cnt & 16'hFFFF));
    checkOutput("rx_drop", 32'(rx_drop_count), 32'(exp_drop));
  endtask

  task automatic applyStimulus(input bit en, input bit txv, input logic [15:0] txd,
                               input logic [5:0] txdest, input bit ov,
                               input logic [15:0] od, input bit rxr);
    tx_enable     = en;
    host_tx_valid = txv;
    host_tx_data  = txd;
    host_tx_dest  = txdest;
    gpu_out_valid = ov;
    gpu_out_data  = od;
    host_rx_ready = rxr;
    modelEdge(cyc + 1, en, txv, {txdest, txd}, ov, od, rxr);
    @(posedge clk);
    #1;
    cyc++;
    checkAll();
  endtask

  task automatic idle(input int n, input bit en, input bit rxr);
    for (int i = 0; i < n; i++) applyStimulus(en, 0, '0, '0, 0, '0, rxr);
  endtask

  int pulses;

  initial begin
    // Power-on reset
    modelReset();
    #12;
    checkAll();
    checkOutput("rst_rx_data", 32'(host_rx_data), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Single flit: visible the cycle after the push edge
    applyStimulus(1, 1, 16'hA5A5, 6'h23, 0, '0, 0);
    applyStimulus(1, 0, '0, '0, 0, '0, 0);
    checkOutput("basic_valid", 32'(gpu_in_valid), 32'h1);
    checkOutput("basic_dest", 32'(gpu_dest_addr), 32'h23);
    checkOutput("basic_data", 32'(gpu_in_data), 32'hA5A5);
    idle(4, 1, 0);
    checkOutput("basic_cnt", 32'(tx_flit_count), 32'h1);

    // Pacing: four back-to-back pushes
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 16'(16'h1000 + i), 6'(i + 8), 0, '0, 0);
    idle(14, 1, 0);

    // Full TX FIFO with transmission held off
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 16'(16'h2000 + i), 6'(i), 0, '0, 0);
      if (i == 7) checkOutput("full_ready", 32'(host_tx_ready), 32'h0);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, 0, '0, '0, 0, '0, 0);
      if (gpu_in_valid) pulses++;
    end
    checkOutput("drain_pulses", 32'(pulses), 32'd8);

    // RX overflow: ten flits into an eight-entry FIFO
    for (int i = 1; i <= 10; i++) applyStimulus(0, 0, '0, '0, 1, 16'(i), 0);
    checkOutput("ovf_rx_cnt", 32'(rx_flit_count), 32'd8);
    checkOutput("ovf_drop", 32'(rx_drop_count), 32'd2);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("ovf_pop", 32'(host_rx_data), 32'(i));
      applyStimulus(0, 0, '0, '0, 0, '0, 1);
    end
    idle(2, 0, 1);

    // RX full with simultaneous write and pop
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, '0, 1, 16'(16'h3000 + i), 0);
    applyStimulus(0, 0, '0, '0, 1, 16'hBEEF, 1);
    checkOutput("sim_drop", 32'(rx_drop_count), 32'd2);
    checkOutput("sim_head", 32'(host_rx_data), 32'h3001);
    checkOutput("sim_cnt", 32'(rx_flit_count), 32'd17);
    idle(10, 0, 1);

    // Random traffic on both directions
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
                    6'($urandom), $urandom_range(0, 1) == 1, 16'($urandom),
                    $urandom_range(0, 9) < 6);
    idle(40, 1, 1);

    // Asynchronous reset while a flit is on the wire
    applyStimulus(1, 1, 16'h4001, 6'h11, 0, '0, 0);
    applyStimulus(1, 1, 16'h4002, 6'h12, 0, '0, 0);
    checkOutput("pre_rst_valid", 32'(gpu_in_valid), 32'h1);
    applyStimulus(1, 1, 16'h4003, 6'h13, 1, 16'h5555, 0);
    tx_enable = 1'b0;
    host_tx_valid = 1'b0;
    gpu_out_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst_rx_data2", 32'(host_rx_data), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, '0, '0, 0, '0, 0);
      if (gpu_in_valid) pulses++;
    end
    checkOutput("post_rst_pulses", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
